// File: rtl/prog_pkg.sv
// prog_pkg: shared types and constants for the UART program loader.
// Holds the RX and loader FSM state encodings, the word geometry
// (four bytes per instruction word) and the UART line-level constants.
// Optional build macro: UART_PARITY_EN adds an even-parity bit (8E1 frames).
package prog_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;

    // UART line levels; data bits travel LSB first.
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_STOP   = 3'd3,
        RX_WAIT   = 3'd4
`ifdef UART_PARITY_EN
        ,
        RX_PARITY = 3'd5
`endif
    } rx_state_e;

    typedef enum logic [1:0] {
        LD_OFF  = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

`ifdef UART_PARITY_EN
    // Even parity: the parity bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: UART byte receiver (8N1, or 8E1 with UART_PARITY_EN).
// Ports:
//   clk, rst (async active-low), rx (async line, idle high)
//   rx_sync    : 2-FF synchronized rx
//   byte_data  : last assembled byte (valid with byte_valid)
//   byte_valid : 1-cycle pulse in the cycle the good stop bit is sampled
//   frame_bad  : 1-cycle pulse when a byte is dropped (bad stop/parity)
module uart_rx_byte
    import prog_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       rx_sync,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       frame_bad
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic            rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            fall_s, tick_bit_s, tick_half_s, good_s;
`ifdef UART_PARITY_EN
    logic            par_bad_q, par_bad_d;
`endif

    assign fall_s      = rx_prev_q & ~rx_sync_q;
    assign tick_bit_s  = (cnt_q == CNT_FULL);
    assign tick_half_s = (cnt_q == CNT_HALF);

    // Synchronizer and state registers; the line resets to idle so activity
    // during reset cannot look like a start bit edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= LINE_IDLE;
            rx_sync_q <= LINE_IDLE;
            rx_prev_q <= LINE_IDLE;
            state_q   <= RX_IDLE;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'h00;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state logic: bit timer, bit index and shift register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (fall_s) state_d = RX_START;
                else        state_d = RX_IDLE;
            end
            RX_START: begin
                if (tick_half_s) begin
                    cnt_d = '0;
                    bit_d = 3'd0;
`ifdef UART_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    // Mid-start-bit check rejects glitches.
                    if (rx_sync_q == LINE_START) state_d = RX_DATA;
                    else                         state_d = RX_IDLE;
                end else begin
                    state_d = RX_START;
                end
            end
            RX_DATA: begin
                if (tick_bit_s) begin
                    cnt_d   = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d = RX_DATA;
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick_bit_s) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_sync_q != even_parity(shift_q));
                    state_d   = RX_STOP;
                end else begin
                    state_d = RX_PARITY;
                end
            end
`endif
            RX_STOP: begin
                if (tick_bit_s) begin
                    cnt_d = '0;
                    if (rx_sync_q == LINE_STOP) state_d = RX_IDLE;
                    else                        state_d = RX_WAIT;
                end else begin
                    state_d = RX_STOP;
                end
            end
            RX_WAIT: begin
                // Broken frame: wait for the line to return high.
                cnt_d = '0;
                if (rx_sync_q == LINE_IDLE) state_d = RX_IDLE;
                else                        state_d = RX_WAIT;
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs: byte accept/reject decided at the stop-bit sample point.
`ifdef UART_PARITY_EN
    assign good_s = (rx_sync_q == LINE_STOP) & ~par_bad_q;
`else
    assign good_s = (rx_sync_q == LINE_STOP);
`endif

    always_comb begin
        byte_valid = 1'b0;
        frame_bad  = 1'b0;
        if (state_q == RX_STOP && tick_bit_s) begin
            byte_valid = good_s;
            frame_bad  = ~good_s;
        end else begin
            byte_valid = 1'b0;
            frame_bad  = 1'b0;
        end
    end

    assign byte_data = shift_q;
    assign rx_sync   = rx_sync_q;

endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: serial program loader for instruction memory.
// Bytes received over UART while start_pg is high are packed little-endian
// into 32-bit words and written with a single-cycle prog_we strobe.
// Optional build macro: UART_PARITY_EN (8E1 frames instead of 8N1).
// Ports:
//   clk, rst (async active-low), start_pg (async level), rx (async)
//   prog_we/prog_addr/prog_data : instruction memory write port
//   prog_active : loading (CPU held in reset); prog_done : load finished
//   frame_err   : sticky bad frame since last start_pg rise
//   rx_led      : inverted synchronized rx
module uart_prog_loader
    import prog_pkg::*;
#(
    parameter int CLKS_PER_BIT      = 868,
    parameter int ADDR_W            = 14,
    parameter int IDLE_TIMEOUT_BITS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_pg,
    input  logic              rx,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [31:0]       prog_data,
    output logic              prog_active,
    output logic              prog_done,
    output logic              frame_err,
    output logic              rx_led
);

    localparam int TMO   = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
    localparam logic [1:0]        LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic              rx_sync_s, byte_valid_s, frame_bad_s;
    logic [7:0]        byte_data_s;
    logic              st_meta_q, st_sync_q, st_prev_q, rise_s, fall_s;
    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       data_q, data_d;
    logic              we_q, we_d, ferr_q, ferr_d, got_q, got_d, led_q;
    logic [TMO_W-1:0]  tmo_q, tmo_d;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_sync    (rx_sync_s),
        .byte_data  (byte_data_s),
        .byte_valid (byte_valid_s),
        .frame_bad  (frame_bad_s)
    );

    assign rise_s = st_sync_q & ~st_prev_q;
    assign fall_s = ~st_sync_q & st_prev_q;

    // State register, start_pg synchronizer and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_meta_q <= 1'b0;
            st_sync_q <= 1'b0;
            st_prev_q <= 1'b0;
            state_q   <= LD_OFF;
            addr_q    <= '0;
            cnt_q     <= 2'd0;
            word_q    <= 24'h0;
            data_q    <= 32'h0;
            we_q      <= 1'b0;
            ferr_q    <= 1'b0;
            got_q     <= 1'b0;
            tmo_q     <= '0;
            led_q     <= 1'b0;
        end else begin
            st_meta_q <= start_pg;
            st_sync_q <= st_meta_q;
            st_prev_q <= st_sync_q;
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            data_q    <= data_d;
            we_q      <= we_d;
            ferr_q    <= ferr_d;
            got_q     <= got_d;
            tmo_q     <= tmo_d;
            led_q     <= ~rx_sync_s;
        end
    end

    // Next-state logic for the loader FSM and its datapath.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        data_d  = data_q;
        we_d    = 1'b0;
        ferr_d  = ferr_q | frame_bad_s;
        got_d   = got_q;
        tmo_d   = tmo_q;
        // Address advances the cycle after the strobe; saturates at the top.
        if (we_q && addr_q != ADDR_MAX) addr_d = addr_q + ADDR_W'(1);
        else                            addr_d = addr_q;
        if (rise_s) begin
            // Any start_pg rise (re)starts a load from address 0.
            state_d = LD_LOAD;
            addr_d  = '0;
            cnt_d   = 2'd0;
            ferr_d  = 1'b0;
            got_d   = 1'b0;
            tmo_d   = '0;
        end else begin
            case (state_q)
                LD_LOAD: begin
                    if (fall_s) begin
                        state_d = LD_DONE;
                    end else if (byte_valid_s) begin
                        got_d = 1'b1;
                        tmo_d = '0;
                        if (cnt_q == LAST_LANE) begin
                            we_d   = 1'b1;
                            data_d = {byte_data_s, word_q};
                            cnt_d  = 2'd0;
                            if (addr_q == ADDR_MAX) state_d = LD_DONE;
                            else                    state_d = LD_LOAD;
                        end else begin
                            case (cnt_q)
                                2'd0:    word_d[7:0]   = byte_data_s;
                                2'd1:    word_d[15:8]  = byte_data_s;
                                default: word_d[23:16] = byte_data_s;
                            endcase
                            cnt_d = cnt_q + 2'd1;
                        end
                    end else if (frame_bad_s) begin
                        cnt_d = 2'd0;
                    end else if (got_q) begin
                        if (tmo_q == TMO_W'(TMO - 1)) state_d = LD_DONE;
                        else                          tmo_d   = tmo_q + TMO_W'(1);
                    end else begin
                        state_d = LD_LOAD;
                    end
                end
                LD_OFF:  state_d = LD_OFF;
                LD_DONE: state_d = LD_DONE;
                default: state_d = LD_OFF;
            endcase
        end
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        prog_active = 1'b0;
        prog_done   = 1'b0;
        case (state_q)
            LD_LOAD: prog_active = 1'b1;
            LD_DONE: prog_done   = 1'b1;
            default: begin
                prog_active = 1'b0;
                prog_done   = 1'b0;
            end
        endcase
    end

    assign prog_we   = we_q;
    assign prog_addr = addr_q;
    assign prog_data = data_q;
    assign frame_err = ferr_q;
    assign rx_led    = led_q;

endmodule

// File: tb/tb_uart_prog_loader.sv
module tb_uart_prog_loader;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start_a = 1'b0, rx_a = 1'b1;
    logic start_b = 1'b0, rx_b = 1'b1;

    logic        we_a, act_a, done_a, ferr_a, led_a;
    logic [13:0] addr_a;
    logic [31:0] data_a;
    logic        we_b, act_b, done_b, ferr_b, led_b;
    logic [1:0]  addr_b;
    logic [31:0] data_b;

    int checks = 0, passes = 0, writes_a = 0, writes_b = 0;
    logic [63:0] q_a[$];
    logic [63:0] q_b[$];

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(14), .IDLE_TIMEOUT_BITS(64)) dut (
        .clk(clk), .rst(rst), .start_pg(start_a), .rx(rx_a),
        .prog_we(we_a), .prog_addr(addr_a), .prog_data(data_a),
        .prog_active(act_a), .prog_done(done_a), .frame_err(ferr_a), .rx_led(led_a)
    );

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(2), .IDLE_TIMEOUT_BITS(64)) dut_s (
        .clk(clk), .rst(rst), .start_pg(start_b), .rx(rx_b),
        .prog_we(we_b), .prog_addr(addr_b), .prog_data(data_b),
        .prog_active(act_b), .prog_done(done_b), .frame_err(ferr_b), .rx_led(led_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Scoreboard: every write strobe is popped against the expected queue.
    always @(negedge clk) begin
        if (rst && we_a) begin
            writes_a++;
            if (q_a.size() > 0) begin
                logic [63:0] e;
                e = q_a.pop_front();
                chk("wr_addr_a", 32'(addr_a), e[63:32]);
                chk("wr_data_a", data_a, e[31:0]);
            end else begin
                chk("unexpected_we_a", 32'd1, 32'd0);
            end
        end
        if (rst && we_b) begin
            writes_b++;
            if (q_b.size() > 0) begin
                logic [63:0] e;
                e = q_b.pop_front();
                chk("wr_addr_b", 32'(addr_b), e[63:32]);
                chk("wr_data_b", data_b, e[31:0]);
            end else begin
                chk("unexpected_we_b", 32'd1, 32'd0);
            end
        end
    end

    task automatic drive(input bit sel, input logic v);
        if (sel) rx_b = v;
        else     rx_a = v;
    endtask

    task automatic bits(input int n);
        repeat (n * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
        drive(sel, 1'b0); bits(1);
        for (int i = 0; i < 8; i++) begin
            drive(sel, b[i]); bits(1);
        end
        drive(sel, stop); bits(1);
        drive(sel, 1'b1); bits(1);
    endtask

    task automatic send_word(input bit sel, input int addr, input logic [31:0] w, input bit expect_wr);
        if (expect_wr) begin
            if (sel) q_b.push_back({32'(addr), w});
            else     q_a.push_back({32'(addr), w});
        end
        for (int i = 0; i < 4; i++) send_byte(sel, w[8*i +: 8], 1'b1);
    endtask

    initial begin
        // Reset state
        repeat (5) @(negedge clk);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_addr", 32'(addr_a), 32'd0);
        chk("rst_active", 32'(act_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_led", 32'(led_a), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Single word 0x12345678 at address 0
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        chk("load_active", 32'(act_a), 32'd1);
        send_word(1'b0, 0, 32'h12345678, 1'b1);
        chk("addr_after_1", 32'(addr_a), 32'd1);

        // Restart via start_pg low/high, then two words
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("fall_done", 32'(done_a), 32'd1);
        chk("fall_active", 32'(act_a), 32'd0);
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        chk("rise_done", 32'(done_a), 32'd0);
        chk("rise_addr", 32'(addr_a), 32'd0);
        send_word(1'b0, 0, 32'h04030201, 1'b1);
        send_word(1'b0, 1, 32'h08070605, 1'b1);
        chk("addr_after_2w", 32'(addr_a), 32'd2);

        // Six bytes then idle timeout: one write, partial word dropped
        send_word(1'b0, 2, 32'h0C0B0A09, 1'b1);
        send_byte(1'b0, 8'h0D, 1'b1);
        send_byte(1'b0, 8'h0E, 1'b1);
        bits(70);
        chk("tmo_done", 32'(done_a), 32'd1);
        chk("tmo_active", 32'(act_a), 32'd0);
        chk("tmo_addr", 32'(addr_a), 32'd3);
        chk("tmo_writes", 32'(writes_a), 32'd4);

        // Framing error mid-word
        start_a = 1'b0;
        repeat (6) @(negedge clk);
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        send_word(1'b0, 0, 32'h14131211, 1'b1);
        send_byte(1'b0, 8'h55, 1'b1);
        send_byte(1'b0, 8'h66, 1'b0);
        chk("frame_err_set", 32'(ferr_a), 32'd1);
        send_word(1'b0, 1, 32'hDDCCBBAA, 1'b1);
        chk("ferr_addr", 32'(addr_a), 32'd2);
        chk("ferr_sticky", 32'(ferr_a), 32'd1);

        // Reset in the middle of the third byte
        send_byte(1'b0, 8'h21, 1'b1);
        send_byte(1'b0, 8'h22, 1'b1);
        drive(1'b0, 1'b0); bits(1);
        drive(1'b0, 1'b1); bits(1);
        drive(1'b0, 1'b0); bits(1);
        rst = 1'b0;
        #1;
        chk("mid_rst_data", data_a, 32'd0);
        chk("mid_rst_addr", 32'(addr_a), 32'd0);
        chk("mid_rst_ferr", 32'(ferr_a), 32'd0);
        chk("mid_rst_active", 32'(act_a), 32'd0);
        chk("mid_rst_led", 32'(led_a), 32'd0);
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        bits(5);
        drive(1'b0, 1'b1); bits(8);
        start_a = 1'b1;
        repeat (6) @(negedge clk);
        chk("rerise_active", 32'(act_a), 32'd1);
        chk("rerise_ferr", 32'(ferr_a), 32'd0);
        send_word(1'b0, 0, 32'h44332211, 1'b1);
        chk("post_rst_addr", 32'(addr_a), 32'd1);

        // Small memory: five words, only four writes
        start_b = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 5; k++)
            send_word(1'b1, k, 32'hB0A09000 + 32'(k * 32'h01010101), k < 4);
        chk("full_done", 32'(done_b), 32'd1);
        chk("full_active", 32'(act_b), 32'd0);
        chk("full_addr", 32'(addr_b), 32'd3);
        chk("full_writes", 32'(writes_b), 32'd4);

        // Final scoreboard drain
        repeat (10) @(negedge clk);
        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        chk("writes_a_total", 32'(writes_a), 32'd7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
Name: uart_prog_loader

Overview:
- Serial program loader that sits directly upstream of the CPU core and its instruction memory.
- Receives 8N1 UART bytes on rx while programming mode is armed by start_pg.
- Assembles bytes little-endian into 32-bit words and issues one write strobe per word to instruction memory.
- Drives the programming status LEDs and holds the CPU off until loading completes.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- ADDR_W, 14, word-address width of instruction memory.
- IDLE_TIMEOUT_BITS, 64, idle bit-times after the last byte that end a load.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start_pg  in  1  programming request (level, async); sync to clk inside.
- rx  in  1  UART receive line, idle high (async).
- prog_we  out  1  one-cycle write strobe to instruction memory.
- prog_addr  out  ADDR_W  word address for prog_we.
- prog_data  out  32  word data for prog_we.
- prog_active  out  1  high while loading; CPU held in reset.
- prog_done  out  1  high after a load ends, until the next start_pg rise.
- frame_err  out  1  sticky: a bad stop bit was seen since the last start_pg rise.
- rx_led  out  1  synchronized rx, inverted (lit while line active).

Behaviour:
- Reset (rst=0, async): all outputs 0; FSMs to IDLE/OFF; address, byte counter and timeout counter cleared.
- Sync: rx and start_pg each pass through a 2-FF synchronizer (2-cycle latency). A start_pg rise is detected on the synchronized signal.
- RX FSM states:
  - IDLE: a falling edge on synced rx goes to START.
  - START: wait CLKS_PER_BIT/2; if rx is still 0, go to DATA; else return to IDLE (glitch).
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. rx=1 gives byte_valid for 1 cycle. rx=0 drops the byte, sets frame_err, resets the byte-in-word counter to 0, and waits for rx=1 before IDLE.
- Loader FSM states:
  - OFF: start_pg rise goes to LOAD; clears prog_addr, byte count, frame_err and prog_done.
  - LOAD: prog_active=1. Each byte_valid shifts into byte lane [count]; lane 0 holds bits 7:0.
    - On the 4th byte: prog_we=1 for exactly 1 cycle, in the cycle after the stop bit is sampled. prog_data and prog_addr are valid in that cycle. prog_addr increments on the following cycle.
    - The timeout counter resets on every byte_valid and counts only after at least one byte has been received.
    - Timeout of IDLE_TIMEOUT_BITS*CLKS_PER_BIT cycles, or start_pg falling, goes to DONE.
  - DONE: prog_active=0, prog_done=1; a partial word (1-3 bytes) is discarded. A start_pg rise goes to LOAD.
- Full: after the write to address 2^ADDR_W-1, go to DONE immediately; there is no wrap-around. Further bytes are ignored.
- start_pg rise while in LOAD restarts the load at address 0 and discards any partial word.
- Bytes received in OFF or DONE are decoded but ignored.
- rx activity during reset is ignored; after reset, a byte whose start bit began during reset is rejected by the START check or counted as a framing error.

Optional Feature:
- UART_PARITY_EN defined: frames are 8E1, with an added PARITY state after DATA.
  - Even-parity mismatch drops the byte, sets frame_err and resets the byte-in-word counter.
- Undefined: 8N1, no PARITY state, no parity logic.

Decomposition:
- Shared package prog_pkg:
  - RX state and loader state enum typedefs.
  - BYTES_PER_WORD=4.
  - UART bit-order constants.
- One natural sub-module: uart_rx_byte. It contains the synchronizer, RX FSM and bit timer, and outputs byte_data[7:0], byte_valid and frame_bad.
- uart_prog_loader instantiates uart_rx_byte and contains the loader FSM.

Test Plan:
- Bench CLKS_PER_BIT=16. Pulse start_pg, then send bytes 0x78,0x56,0x34,0x12 → prog_active=1; a single prog_we pulse with prog_addr=0, prog_data=0x12345678.
- Send 8 bytes 0x01..0x08 → writes addr0=0x04030201, addr1=0x08070605; prog_addr=2 afterwards.
- Send 6 bytes, then idle 64 bit-times → exactly 1 write; prog_done=1, prog_active=0; partial word discarded.
- Send a byte with stop bit=0 mid-word, then 4 good bytes 0xAA,0xBB,0xCC,0xDD → frame_err=1; next write data=0xDDCCBBAA at the next address.
- Assert rst low in the middle of the 3rd byte → all outputs 0 immediately. After release and a start_pg rise, a 4-byte word writes at addr 0.
- ADDR_W=2: send 5 words → 4 writes (addr 0..3); DONE after addr 3; the 5th word causes no prog_we.
